tc_array: RTL and testbench

Parametrised multi-channel timer/counter, the successor to the single fixed-width timer behind the system bridge. It packs N_CH independent down-counters into one bridge device slot. Each channel has a power-of-two prescaler, one-shot and auto-reload modes, and a sticky write-1-to-clear interrupt flag. Per-channel masked IRQs are also OR-reduced into one line for the bridge's HWInt vector.

---
 rtl/tc_pkg.sv | 31 +++
 rtl/tc_channel.sv | 148 ++++++++++++++
 rtl/tc_array.sv | 63 ++++++
 tb/tb_tc_array.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the tc_array timer/counter block: channel FSM states,
// mode encodings, register word offsets and CTRL field layout.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } tc_state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam int CTRL_PSC  = 4;
    localparam int PSC_W     = 4;

    // Both 1x encodings freeze the channel.
    function automatic logic is_hold(input logic [1:0] mode);
        return (mode != MODE_ONESHOT) && (mode != MODE_RELOAD);
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer/counter channel: CTRL/PRESET/COUNT/STATUS registers, power-of-two
// prescaler and the load/count/interrupt sequencing FSM.
//
// state   | meaning
// IDLE    | stopped, COUNT holds its last value
// LOAD    | COUNT <- PRESET, prescaler cleared
// CNT     | counting down one step per prescaler tick
// INT     | terminal reached; reload or drop EN depending on MODE
module tc_channel
    import tc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    tc_state_e        state;
    logic             ctrl_en;
    logic             ctrl_im;
    logic [1:0]       ctrl_mode;
    logic [PSC_W-1:0] ctrl_psc;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             pending;
    logic [15:0]      presc;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        wr_status;
    logic        stop;
    logic        en_nxt;
    logic [1:0]  mode_nxt;
    logic [15:0] psc_lim;
    logic        tick;
    logic        hit_zero;
    logic        terminal;
    logic        unused_din;

    assign wr_ctrl   = we && (sel == REG_CTRL);
    assign wr_preset = we && (sel == REG_PRESET);
    assign wr_status = we && (sel == REG_STATUS);

    // A CTRL write with EN=0 overrides whatever the FSM would do this edge.
    assign stop     = wr_ctrl && !din[CTRL_EN];
    assign en_nxt   = wr_ctrl ? din[CTRL_EN] : ctrl_en;
    assign mode_nxt = wr_ctrl ? din[CTRL_MODE +: 2] : ctrl_mode;

    // >= keeps the prescaler sane if PSC shrinks below its current value.
    assign psc_lim  = (16'd1 << ctrl_psc) - 16'd1;
    assign tick     = (presc >= psc_lim);
    assign hit_zero = (count <= WIDTH'(1));
    assign terminal = !stop && (state == ST_CNT) && !is_hold(ctrl_mode) && tick && hit_zero;

    assign unused_din = ^din[31:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_im   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_psc  <= '0;
            preset    <= '0;
            count     <= '0;
            pending   <= 1'b0;
            presc     <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= din[CTRL_EN];
                ctrl_mode <= din[CTRL_MODE +: 2];
                ctrl_im   <= din[CTRL_IM];
                ctrl_psc  <= din[CTRL_PSC +: PSC_W];
            end
            if (wr_preset) begin
                preset <= din[WIDTH-1:0];
            end
            // Set after clear so a same-edge terminal event wins over W1C.
            if (wr_status && din[0]) begin
                pending <= 1'b0;
            end
            if (terminal) begin
                pending <= 1'b1;
            end

            if (stop) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (en_nxt && !is_hold(mode_nxt)) begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count <= preset;
                        presc <= '0;
                        state <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!is_hold(ctrl_mode)) begin
                            if (tick) begin
                                presc <= '0;
                                if (hit_zero) begin
                                    count <= '0;
                                    state <= ST_INT;
                                end else begin
                                    count <= count - WIDTH'(1);
                                end
                            end else begin
                                presc <= presc + 16'd1;
                            end
                        end
                    end
                    ST_INT: begin
                        if (ctrl_mode == MODE_RELOAD) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            if (!wr_ctrl) begin
                                ctrl_en <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dout = '0;
        case (sel)
            REG_CTRL:   dout = {24'd0, ctrl_psc, ctrl_im, ctrl_mode, ctrl_en};
            REG_PRESET: dout = 32'(preset);
            REG_COUNT:  dout = 32'(count);
            default:    dout = {31'd0, pending};
        endcase
    end

    assign irq = pending && ctrl_im;

endmodule

// File: rtl/tc_array.sv
// N_CH independent timer/counter channels behind one bridge slot: channel
// decode with out-of-range guard, zero-latency read mux and IRQ OR-reduction.
module tc_array
    import tc_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic [N_CH-1:0] irq,
    output logic            IRQ
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    // One extra index bit so addresses just past the last channel decode as
    // out of range instead of aliasing onto a real channel.
    localparam int IDX_W = CH_W + 1;

    logic [IDX_W-1:0] ch_idx;
    logic [1:0]       reg_sel;
    logic             ch_ok;
    logic [N_CH-1:0]  ch_we;
    logic [31:0]      ch_dout [N_CH];
    logic             unused_addr;

    assign ch_idx      = Addr[4+CH_W:4];
    assign reg_sel     = Addr[3:2];
    assign ch_ok       = (32'(ch_idx) < 32'(N_CH));
    assign unused_addr = ^Addr[31:5+CH_W];

    always_comb begin
        Dout  = '0;
        ch_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_ok && (ch_idx == IDX_W'(i))) begin
                Dout     = ch_dout[i];
                ch_we[i] = WE;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tc_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .we    (ch_we[g]),
            .sel   (reg_sel),
            .din   (Din),
            .dout  (ch_dout[g]),
            .irq   (irq[g])
        );
    end

    assign IRQ = |irq;

endmodule

// File: tb/tb_tc_array.sv
// Self-checking bench for tc_array: directed scenarios plus randomized channel
// runs compared against a closed-form timeline model of each channel.
module tb_tc_array;
    import tc_pkg::*;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    logic            clk;
    logic            reset;
    logic [31:2]     Addr;
    logic            WE;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic [N_CH-1:0] irq;
    logic            IRQ;

    int n_chk = 0;
    int n_err = 0;

    tc_array #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .irq   (irq),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [1:0] r);
        Addr = '0;
        Addr[3:2] = r;
        Addr[8:4] = 5'(ch);
    endtask

    task automatic rd(input int ch, input logic [1:0] r, output logic [31:0] v);
        set_addr(ch, r);
        #1;
        v = Dout;
    endtask

    task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] data);
        set_addr(ch, r);
        Din = data;
        WE  = 1'b1;
        tick_clk();
        WE  = 1'b0;
    endtask

    // Timeline model: d = rising edges since the enabling CTRL write.
    // Load lands on edge 1, then one step every 2^psc edges; auto-reload
    // repeats with period P*2^psc + 2.
    function automatic int phase(input int d, input int pre, input int psc, input int mode);
        int p, per;
        p   = (pre == 0) ? 1 : pre;
        per = 1 << psc;
        return (mode == 1) ? (d - 1) % (p * per + 2) : d - 1;
    endfunction

    function automatic int exp_count(input int d, input int pre, input int psc, input int mode);
        int p, j;
        p = (pre == 0) ? 1 : pre;
        j = phase(d, pre, psc, mode) / (1 << psc);
        if (j == 0) return pre;
        return (j >= p) ? 0 : p - j;
    endfunction

    function automatic bit is_term(input int d, input int pre, input int psc, input int mode);
        int p;
        p = (pre == 0) ? 1 : pre;
        return phase(d, pre, psc, mode) == p * (1 << psc);
    endfunction

    task automatic run_ch(input int ch, input int pre, input int psc, input int mode, input int im,
                          input int n, input int w1c_d, input bit rnd_w1c);
        logic [31:0] v, junk, exp_irq;
        bit          pend, w1c, en_exp;
        int          p;
        p = (pre == 0) ? 1 : pre;
        wr(ch, REG_PRESET, 32'(pre));
        junk = $urandom();
        junk[7:0] = {psc[3:0], im[0], mode[1:0], 1'b1};
        wr(ch, REG_CTRL, junk);
        pend = 1'b0;
        for (int d = 1; d <= n; d++) begin
            w1c = (d == w1c_d) || (rnd_w1c && ($urandom_range(0, 7) == 0));
            if (w1c) begin
                set_addr(ch, REG_STATUS);
                Din = 32'd1;
                WE  = 1'b1;
            end
            tick_clk();
            WE = 1'b0;
            if (w1c) pend = 1'b0;
            if (is_term(d, pre, psc, mode)) pend = 1'b1;
            exp_irq = (pend && im != 0) ? (32'd1 << ch) : 32'd0;
            rd(ch, REG_COUNT, v);
            check("count", v, 32'(exp_count(d, pre, psc, mode)));
            rd(ch, REG_STATUS, v);
            check("pending", v, {31'd0, pend});
            check("irq", 32'(irq), exp_irq);
            check("IRQ", {31'd0, IRQ}, {31'd0, exp_irq != 0});
        end
        en_exp = !(mode == 0 && n >= p * (1 << psc) + 2);
        rd(ch, REG_CTRL, v);
        check("ctrl", v, {24'd0, psc[3:0], im[0], mode[1:0], en_exp});
        wr(ch, REG_CTRL, {24'd0, psc[3:0], im[0], mode[1:0], 1'b0});
        rd(ch, REG_COUNT, v);
        check("stop_count", v, 32'(exp_count(n, pre, psc, mode)));
        tick_clk();
        rd(ch, REG_COUNT, v);
        check("stop_hold", v, 32'(exp_count(n, pre, psc, mode)));
        wr(ch, REG_STATUS, 32'd1);
        rd(ch, REG_STATUS, v);
        check("w1c_status", v, 32'd0);
        check("w1c_irq", 32'(irq), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int ch, pre, psc, mode, im, n;
        reset = 1'b0;
        WE    = 1'b0;
        Din   = '0;
        Addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick_clk();

        for (int c = 0; c < N_CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, 2'(r), v);
                check("rst_reg", v, 32'd0);
            end
        end
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_IRQ", {31'd0, IRQ}, 32'd0);

        // Channel index 5 is beyond N_CH: writes dropped, reads zero, no aliasing.
        wr(5, REG_PRESET, 32'h0000_00AB);
        wr(5, REG_CTRL, 32'h0000_0009);
        for (int r = 0; r < 4; r++) begin
            rd(5, 2'(r), v);
            check("oor_read", v, 32'd0);
        end
        rd(1, REG_PRESET, v);
        check("oor_alias_preset", v, 32'd0);
        rd(1, REG_CTRL, v);
        check("oor_alias_ctrl", v, 32'd0);

        wr(0, REG_PRESET, 32'h0000_01FF);
        rd(0, REG_PRESET, v);
        check("width_trunc", v, 32'h0000_00FF);

        // Hold mode never leaves IDLE.
        wr(3, REG_PRESET, 32'd4);
        wr(3, REG_CTRL, 32'h0000_0005);
        repeat (6) tick_clk();
        rd(3, REG_COUNT, v);
        check("hold_count", v, 32'd0);
        rd(3, REG_STATUS, v);
        check("hold_pending", v, 32'd0);
        rd(3, REG_CTRL, v);
        check("hold_ctrl", v, 32'h0000_0005);
        wr(3, REG_CTRL, 32'd0);

        run_ch(0, 5, 0, 0, 1, 8, -1, 1'b0);
        run_ch(2, 3, 1, 1, 1, 30, 10, 1'b0);
        run_ch(1, 100, 0, 0, 1, 11, -1, 1'b0);
        rd(1, REG_COUNT, v);
        check("hold90", v, 32'd90);
        repeat (5) tick_clk();
        rd(1, REG_COUNT, v);
        check("hold90_later", v, 32'd90);
        check("hold90_irq", 32'(irq), 32'd0);
        run_ch(1, 100, 0, 0, 1, 3, -1, 1'b0);
        run_ch(3, 0, 0, 0, 1, 4, 2, 1'b0);

        // Asynchronous reset in the middle of a count.
        wr(1, REG_PRESET, 32'd20);
        wr(1, REG_CTRL, 32'h0000_0009);
        repeat (14) tick_clk();
        rd(1, REG_COUNT, v);
        check("pre_rst_count", v, 32'd7);
        #2 reset = 1'b0;
        #1;
        check("rst_async_count", Dout, 32'd0);
        check("rst_async_irq", 32'(irq), 32'd0);
        check("rst_async_IRQ", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) tick_clk();
        rd(1, REG_COUNT, v);
        check("rst_idle_count", v, 32'd0);
        rd(1, REG_CTRL, v);
        check("rst_idle_ctrl", v, 32'd0);

        for (int k = 0; k < 20; k++) begin
            ch   = int'($urandom_range(0, N_CH - 1));
            pre  = int'($urandom_range(0, 12));
            psc  = int'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 1));
            im   = int'($urandom_range(0, 1));
            n    = int'($urandom_range(4, 50));
            run_ch(ch, pre, psc, mode, im, n, -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
